// File: rtl/regfile_dbg_pkg.sv
// Shared types and constants for the register-file debug controller.
package regfile_dbg_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 16;
  localparam logic [REG_AW-1:0] LAST_REG = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  // Saturating increment keeps a stuck pipeline from wrapping the starve count back to zero.
  function automatic logic [2:0] sat_inc3(input logic [2:0] value);
    return (value == 3'd7) ? value : value + 3'd1;
  endfunction

endpackage

// File: rtl/regfile_dump_seq.sv
// Register dump sequencer: walks every register once and streams it out with valid/ready.
module regfile_dump_seq
  import regfile_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [REG_AW-1:0] cpu_raddr1,
  input  logic [REG_DW-1:0] rf_rdata1,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic [REG_AW-1:0] dump_addr,
  output logic [REG_DW-1:0] dump_data,
  output logic [REG_AW-1:0] rf_raddr1
);

  dump_state_e       state_r, state_next_s;
  logic [REG_AW-1:0] idx_r, idx_next_s;
  logic [REG_AW-1:0] addr_next_s;
  logic [REG_DW-1:0] data_next_s;

  // State, index and beat registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      idx_r     <= 4'd0;
      dump_addr <= 4'd0;
      dump_data <= 16'd0;
    end else begin
      state_r   <= state_next_s;
      idx_r     <= idx_next_s;
      dump_addr <= addr_next_s;
      dump_data <= data_next_s;
    end
  end

  // Next-state logic; the beat registers only load in READ so they hold through SEND back-pressure.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    addr_next_s  = dump_addr;
    data_next_s  = dump_data;
    case (state_r)
      IDLE: begin
        if (dump_start) begin
          state_next_s = READ;
          idx_next_s   = 4'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        data_next_s  = rf_rdata1;
        addr_next_s  = idx_r;
        state_next_s = SEND;
      end
      SEND: begin
        if (dump_ready && (idx_r == LAST_REG)) begin
          state_next_s = DONE;
        end else if (dump_ready) begin
          idx_next_s   = idx_r + 4'd1;
          state_next_s = READ;
        end else begin
          state_next_s = SEND;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign dump_valid = (state_r == SEND);
  assign dump_busy  = (state_r != IDLE);
  assign rf_raddr1  = (state_r == READ) ? idx_r : cpu_raddr1;

endmodule

// File: rtl/regfile_dbg_controller.sv
// Register-file write arbiter (pipeline vs debug) with starvation stall and optional register dump.
// The dump sequencer is built only when REGFILE_DBG_DUMP_EN is defined.
module regfile_dbg_controller
  import regfile_dbg_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [REG_AW-1:0] cpu_waddr,
  input  logic [REG_DW-1:0] cpu_wdata,
  input  logic [REG_AW-1:0] cpu_raddr1,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic [REG_DW-1:0] dbg_wdata,
  output logic              dbg_ack,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_addr,
  output logic [REG_DW-1:0] dump_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata,
  output logic [REG_AW-1:0] rf_raddr1,
  input  logic [REG_DW-1:0] rf_rdata1
);

  logic [2:0] starve_r;
  logic       grant_s;

  // Write port arbitration: pipeline first, debug only in cycles the pipeline leaves free.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = 16'd0;
    grant_s  = 1'b0;
    if (!reset) begin
      rf_we = 1'b0;
    end else if (cpu_we) begin
      rf_we    = 1'b1;
      rf_waddr = cpu_waddr;
      rf_wdata = cpu_wdata;
    end else if (dbg_req) begin
      rf_we    = 1'b1;
      rf_waddr = dbg_addr;
      rf_wdata = dbg_wdata;
      grant_s  = 1'b1;
    end else begin
      rf_we = 1'b0;
    end
  end

  assign dbg_ack = grant_s;

  // Starve counter: counts blocked debug cycles, cleared by a grant or a dropped request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_r <= 3'd0;
    end else if (!dbg_req || grant_s) begin
      starve_r <= 3'd0;
    end else if (cpu_we) begin
      starve_r <= sat_inc3(starve_r);
    end else begin
      starve_r <= starve_r;
    end
  end

  assign cpu_stall = reset & ((starve_r == 3'(STARVE_MAX)) | dump_busy);

`ifdef REGFILE_DBG_DUMP_EN
  regfile_dump_seq u_dump_seq (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .cpu_raddr1 (cpu_raddr1),
    .rf_rdata1  (rf_rdata1),
    .dump_valid (dump_valid),
    .dump_busy  (dump_busy),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .rf_raddr1  (rf_raddr1)
  );
`else
  logic unused_dump_inputs;
  assign unused_dump_inputs = ^{dump_start, dump_ready, rf_rdata1};
  assign dump_valid = 1'b0;
  assign dump_busy  = 1'b0;
  assign dump_addr  = 4'd0;
  assign dump_data  = 16'd0;
  assign rf_raddr1  = cpu_raddr1;
`endif

endmodule
